// File: rtl/spatz_lane_sequencer.sv
// spatz_lane_sequencer: element sequencer in front of one SIMD lane.
// Takes one vector instruction at a time and requests operand triples element
// by element. Each response drives the combinational lane, and the lane result
// returns with its element index on a write-back handshake. Credit-based flow
// control (outstanding + FIFO occupancy) means operand responses never stall.
// Optional feature: define SPATZ_LANE_SEQ_BYPASS_EN for zero-latency write-back
// when the result FIFO is empty.
module spatz_lane_sequencer #(
    parameter int unsigned Width       = 32,
    parameter int unsigned MaxVl       = 256,
    parameter int unsigned ResultDepth = 4,
    parameter int unsigned OpWidth     = 4,
    parameter int unsigned SewWidth    = 2,
    localparam int unsigned VlWidth    = $clog2(MaxVl + 1),
    localparam int unsigned IdxWidth   = VlWidth - 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [OpWidth-1:0]  issue_op_i,
    input  logic [VlWidth-1:0]  issue_vl_i,
    input  logic                issue_signed_i,
    input  logic [SewWidth-1:0] issue_sew_i,
    output logic                opnd_req_valid_o,
    input  logic                opnd_req_ready_i,
    output logic [IdxWidth-1:0] opnd_req_idx_o,
    input  logic                opnd_rsp_valid_i,
    input  logic [Width-1:0]    opnd_rsp_s1_i,
    input  logic [Width-1:0]    opnd_rsp_s2_i,
    input  logic [Width-1:0]    opnd_rsp_d_i,
    input  logic                opnd_rsp_carry_i,
    output logic [OpWidth-1:0]  lane_op_o,
    output logic                lane_signed_o,
    output logic [SewWidth-1:0] lane_sew_o,
    output logic [Width-1:0]    lane_s1_o,
    output logic [Width-1:0]    lane_s2_o,
    output logic [Width-1:0]    lane_d_o,
    output logic                lane_carry_o,
    input  logic [Width-1:0]    lane_result_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [IdxWidth-1:0] wb_idx_o,
    output logic [Width-1:0]    wb_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned CntWidth = $clog2(ResultDepth + 1);
    localparam int unsigned SumWidth = CntWidth + 1;
    localparam int unsigned PtrWidth = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [OpWidth-1:0]  op_q;
    logic                signed_q;
    logic [SewWidth-1:0] sew_q;
    logic [VlWidth-1:0]  vl_q;
    logic [VlWidth-1:0]  req_cnt_q;
    logic [VlWidth-1:0]  rsp_cnt_q;
    logic [VlWidth-1:0]  wb_cnt_q;
    logic [CntWidth-1:0] outstanding_q;
    logic [CntWidth-1:0] fifo_cnt_q;
    logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [IdxWidth-1:0] fifo_idx_q  [ResultDepth];
    logic [Width-1:0]    fifo_data_q [ResultDepth];

    logic                issue_hs;
    logic                req_hs;
    logic                rsp_fire;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                wb_hs;
    logic [SumWidth-1:0] inflight;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(ResultDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Sequencing FSM: handshake outputs and state transitions
    always_comb begin
        state_d       = state_q;
        issue_ready_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i) begin
                    state_d = (issue_vl_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if ((wb_cnt_q + VlWidth'(wb_hs)) == vl_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request credit, lane drive and write-back selection
    always_comb begin
        issue_hs         = issue_valid_i && (state_q == IDLE);
        inflight         = SumWidth'(outstanding_q) + SumWidth'(fifo_cnt_q);
        opnd_req_valid_o = (state_q == RUN) && (req_cnt_q < vl_q)
                           && (inflight < SumWidth'(ResultDepth));
        opnd_req_idx_o   = opnd_req_valid_o ? req_cnt_q[IdxWidth-1:0] : '0;
        req_hs           = opnd_req_valid_o && opnd_req_ready_i;
        rsp_fire         = opnd_rsp_valid_i && (state_q == RUN);

        lane_op_o        = (state_q != IDLE) ? op_q : '0;
        lane_signed_o    = (state_q != IDLE) ? signed_q : 1'b0;
        lane_sew_o       = (state_q != IDLE) ? sew_q : '0;
        lane_s1_o        = rsp_fire ? opnd_rsp_s1_i : '0;
        lane_s2_o        = rsp_fire ? opnd_rsp_s2_i : '0;
        lane_d_o         = rsp_fire ? opnd_rsp_d_i : '0;
        lane_carry_o     = rsp_fire ? opnd_rsp_carry_i : 1'b0;

        fifo_empty       = (fifo_cnt_q == '0);
`ifdef SPATZ_LANE_SEQ_BYPASS_EN
        // Empty FIFO: the lane result goes straight out; it is only stored if refused
        wb_valid_o       = !fifo_empty || rsp_fire;
        if (!fifo_empty) begin
            wb_idx_o  = fifo_idx_q[rd_ptr_q];
            wb_data_o = fifo_data_q[rd_ptr_q];
        end else if (rsp_fire) begin
            wb_idx_o  = rsp_cnt_q[IdxWidth-1:0];
            wb_data_o = lane_result_i;
        end else begin
            wb_idx_o  = '0;
            wb_data_o = '0;
        end
        wb_hs            = wb_valid_o && wb_ready_i;
        push             = rsp_fire && !(fifo_empty && wb_ready_i);
`else
        wb_valid_o       = !fifo_empty;
        wb_idx_o         = fifo_empty ? '0 : fifo_idx_q[rd_ptr_q];
        wb_data_o        = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
        wb_hs            = wb_valid_o && wb_ready_i;
        push             = rsp_fire;
`endif
        pop              = wb_hs && !fifo_empty;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction field latch, taken on the issue handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            signed_q <= 1'b0;
            sew_q    <= '0;
            vl_q     <= '0;
        end else if (issue_hs) begin
            op_q     <= issue_op_i;
            signed_q <= issue_signed_i;
            sew_q    <= issue_sew_i;
            vl_q     <= issue_vl_i;
        end
    end

    // Element counters and outstanding-request tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_cnt_q     <= '0;
            rsp_cnt_q     <= '0;
            wb_cnt_q      <= '0;
            outstanding_q <= '0;
        end else if (issue_hs) begin
            req_cnt_q     <= '0;
            rsp_cnt_q     <= '0;
            wb_cnt_q      <= '0;
            outstanding_q <= '0;
        end else begin
            req_cnt_q <= req_cnt_q + VlWidth'(req_hs);
            rsp_cnt_q <= rsp_cnt_q + VlWidth'(rsp_fire);
            wb_cnt_q  <= wb_cnt_q + VlWidth'(wb_hs);
            unique case ({req_hs, rsp_fire})
                2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Result FIFO holding {index, lane result}
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int unsigned i = 0; i < ResultDepth; i++) begin
                fifo_idx_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_idx_q[wr_ptr_q]  <= rsp_cnt_q[IdxWidth-1:0];
                fifo_data_q[wr_ptr_q] <= lane_result_i;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Responses are only legal in RUN against an outstanding request
    rsp_protocol_a: assert property (@(posedge clk_i) disable iff (rst_i)
        opnd_rsp_valid_i |-> ((state_q == RUN) && (outstanding_q != '0)));

    // Credit accounting guarantees the FIFO never overflows
    fifo_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> ((fifo_cnt_q != CntWidth'(ResultDepth)) || pop));

endmodule

// File: tb/tb_spatz_lane_sequencer.sv
// Directed self-checking bench for spatz_lane_sequencer with a behavioural
// lane (add/sub/mul) and an in-order operand responder with variable latency.
module tb_spatz_lane_sequencer;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;

    logic        clk_i;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  issue_op_i;
    logic [8:0]  issue_vl_i;
    logic        issue_signed_i;
    logic [1:0]  issue_sew_i;
    logic        opnd_req_valid_o;
    logic        opnd_req_ready_i;
    logic [7:0]  opnd_req_idx_o;
    logic        opnd_rsp_valid_i;
    logic [31:0] opnd_rsp_s1_i;
    logic [31:0] opnd_rsp_s2_i;
    logic [31:0] opnd_rsp_d_i;
    logic        opnd_rsp_carry_i;
    logic [3:0]  lane_op_o;
    logic        lane_signed_o;
    logic [1:0]  lane_sew_o;
    logic [31:0] lane_s1_o;
    logic [31:0] lane_s2_o;
    logic [31:0] lane_d_o;
    logic        lane_carry_o;
    logic [31:0] lane_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [7:0]  wb_idx_o;
    logic [31:0] wb_data_o;
    logic        busy_o;
    logic        done_o;

    spatz_lane_sequencer dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_op_i       (issue_op_i),
        .issue_vl_i       (issue_vl_i),
        .issue_signed_i   (issue_signed_i),
        .issue_sew_i      (issue_sew_i),
        .opnd_req_valid_o (opnd_req_valid_o),
        .opnd_req_ready_i (opnd_req_ready_i),
        .opnd_req_idx_o   (opnd_req_idx_o),
        .opnd_rsp_valid_i (opnd_rsp_valid_i),
        .opnd_rsp_s1_i    (opnd_rsp_s1_i),
        .opnd_rsp_s2_i    (opnd_rsp_s2_i),
        .opnd_rsp_d_i     (opnd_rsp_d_i),
        .opnd_rsp_carry_i (opnd_rsp_carry_i),
        .lane_op_o        (lane_op_o),
        .lane_signed_o    (lane_signed_o),
        .lane_sew_o       (lane_sew_o),
        .lane_s1_o        (lane_s1_o),
        .lane_s2_o        (lane_s2_o),
        .lane_d_o         (lane_d_o),
        .lane_carry_o     (lane_carry_o),
        .lane_result_i    (lane_result_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_idx_o         (wb_idx_o),
        .wb_data_o        (wb_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // Behavioural SIMD lane
    always_comb begin
        lane_result_i = '0;
        case (lane_op_o)
            OP_ADD:  lane_result_i = lane_s1_o + lane_s2_o;
            OP_SUB:  lane_result_i = lane_s2_o - lane_s1_o;
            OP_MUL:  lane_result_i = lane_s1_o * lane_s2_o;
            default: lane_result_i = '0;
        endcase
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        int due;
    } req_t;

    int checks;
    int errors;
    int cyc;
    int lat_max;
    int wb_mode;
    int wb_hold_until;
    int s1_k, s1_b, s2_k, s2_b;
    req_t rq[$];
    int          wb_idx_log[$];
    logic [31:0] wb_data_log[$];
    int          wb_cyc_log[$];
    int          done_cyc_log[$];
    int          rsp_cyc_log[$];
    int req_total, wb_total;
    int first_req_cyc, first_wbvalid_cyc;
    int reqs_before_first_wb;
    int max_inflight;
    int stab_errs;
    bit seen_wb;

    task automatic clear_logs();
        wb_idx_log.delete();
        wb_data_log.delete();
        wb_cyc_log.delete();
        done_cyc_log.delete();
        rsp_cyc_log.delete();
        req_total = 0;
        wb_total = 0;
        first_req_cyc = -1;
        first_wbvalid_cyc = -1;
        reqs_before_first_wb = 0;
        max_inflight = 0;
        stab_errs = 0;
        seen_wb = 1'b0;
    endtask

    // Operand responder, write-back sink and observation log
    initial begin : responder
        req_t r;
        bit prev_stall;
        logic [7:0]  prev_idx;
        logic [31:0] prev_data;
        int inflight;
        prev_stall = 1'b0;
        prev_idx = '0;
        prev_data = '0;
        opnd_req_ready_i = 1'b0;
        opnd_rsp_valid_i = 1'b0;
        opnd_rsp_s1_i = '0;
        opnd_rsp_s2_i = '0;
        opnd_rsp_d_i = '0;
        opnd_rsp_carry_i = 1'b0;
        wb_ready_i = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                rq.delete();
                opnd_rsp_valid_i = 1'b0;
                opnd_rsp_s1_i = '0;
                opnd_rsp_s2_i = '0;
                opnd_rsp_d_i = '0;
                opnd_rsp_carry_i = 1'b0;
                opnd_req_ready_i = 1'b0;
                wb_ready_i = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    opnd_rsp_valid_i = 1'b1;
                    opnd_rsp_s1_i = 32'(s1_k * r.idx + s1_b);
                    opnd_rsp_s2_i = 32'(s2_k * r.idx + s2_b);
                    rsp_cyc_log.push_back(cyc);
                end else begin
                    opnd_rsp_valid_i = 1'b0;
                    opnd_rsp_s1_i = '0;
                    opnd_rsp_s2_i = '0;
                end
                opnd_rsp_d_i = '0;
                opnd_rsp_carry_i = 1'b0;
                opnd_req_ready_i = 1'b1;
                case (wb_mode)
                    1:       wb_ready_i = (cyc >= wb_hold_until);
                    2:       wb_ready_i = 1'($urandom_range(0, 1));
                    default: wb_ready_i = 1'b1;
                endcase
                #1;
                inflight = req_total - wb_total;
                if (inflight > max_inflight) max_inflight = inflight;
                if (opnd_req_valid_o && opnd_req_ready_i) begin
                    rq.push_back('{idx: int'(opnd_req_idx_o),
                                   due: cyc + int'($urandom_range(1, lat_max))});
                    if (req_total == 0) first_req_cyc = cyc;
                    req_total++;
                    if (!seen_wb) reqs_before_first_wb++;
                end
                if (prev_stall && (!wb_valid_o || wb_idx_o !== prev_idx || wb_data_o !== prev_data))
                    stab_errs++;
                if (wb_valid_o && first_wbvalid_cyc < 0) first_wbvalid_cyc = cyc;
                if (wb_valid_o && wb_ready_i) begin
                    wb_idx_log.push_back(int'(wb_idx_o));
                    wb_data_log.push_back(wb_data_o);
                    wb_cyc_log.push_back(cyc);
                    wb_total++;
                    seen_wb = 1'b1;
                end
                prev_stall = wb_valid_o && !wb_ready_i;
                prev_idx = wb_idx_o;
                prev_data = wb_data_o;
                if (done_o) done_cyc_log.push_back(cyc);
            end
        end
    end

    // Present one instruction and wait (bounded) for its handshake
    task automatic do_issue(input logic [3:0] op, input logic sgn, input logic [1:0] sew,
                            input int vl, output int icyc);
        @(negedge clk_i);
        #2;
        issue_valid_i = 1'b1;
        issue_op_i = op;
        issue_signed_i = sgn;
        issue_sew_i = sew;
        issue_vl_i = 9'(vl);
        icyc = -1;
        for (int k = 0; k < 50; k++) begin
            if (issue_ready_o) begin
                icyc = cyc;
                break;
            end
            @(negedge clk_i);
            #2;
        end
        @(negedge clk_i);
        #2;
        issue_valid_i = 1'b0;
        issue_op_i = '0;
        issue_vl_i = '0;
        issue_signed_i = 1'b0;
        issue_sew_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        issue_valid_i = 1'b0;
        issue_op_i = '0;
        issue_vl_i = '0;
        issue_signed_i = 1'b0;
        issue_sew_i = '0;
        lat_max = 1;
        wb_mode = 0;
        s1_k = 0; s1_b = 0; s2_k = 0; s2_b = 0;
        clear_logs();
        repeat (3) @(negedge clk_i);
        #2;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (opnd_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", opnd_req_valid_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_o); end
        checks++; if (wb_data_o !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %0d expected 0", wb_data_o); end
        checks++; if (lane_op_o !== 4'd0) begin errors++; $display("FAIL reset_lane_op: got %0d expected 0", lane_op_o); end
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_issue_ready: got %b expected 1", issue_ready_o); end
    endtask

    task automatic test_vadd();
        logic [31:0] exp_data [4];
        int icyc;
        exp_data = '{32'd11, 32'd12, 32'd13, 32'd14};
        s1_k = 1; s1_b = 1; s2_k = 0; s2_b = 10;
        lat_max = 1;
        wb_mode = 0;
        clear_logs();
        do_issue(OP_ADD, 1'b1, 2'd2, 4, icyc);
        checks++; if (icyc < 0) begin errors++; $display("FAIL vadd_issue: got timeout expected handshake"); end
        checks++; if (lane_op_o !== OP_ADD) begin errors++; $display("FAIL vadd_lane_op: got %0d expected %0d", lane_op_o, OP_ADD); end
        checks++; if (lane_signed_o !== 1'b1) begin errors++; $display("FAIL vadd_lane_signed: got %b expected 1", lane_signed_o); end
        checks++; if (lane_sew_o !== 2'd2) begin errors++; $display("FAIL vadd_lane_sew: got %0d expected 2", lane_sew_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL vadd_busy: got %b expected 1", busy_o); end
        for (int k = 0; k < 100 && done_cyc_log.size() == 0; k++) begin
            @(negedge clk_i);
            #2;
        end
        repeat (3) @(negedge clk_i);
        #2;
        checks++; if (first_req_cyc !== icyc + 1) begin errors++; $display("FAIL vadd_first_req_cycle: got %0d expected %0d", first_req_cyc, icyc + 1); end
        checks++; if (wb_idx_log.size() !== 4) begin errors++; $display("FAIL vadd_wb_count: got %0d expected 4", wb_idx_log.size()); end
        for (int i = 0; i < 4 && i < wb_idx_log.size(); i++) begin
            checks++; if (wb_idx_log[i] !== i) begin errors++; $display("FAIL vadd_idx[%0d]: got %0d expected %0d", i, wb_idx_log[i], i); end
            checks++; if (wb_data_log[i] !== exp_data[i]) begin errors++; $display("FAIL vadd_data[%0d]: got %0d expected %0d", i, wb_data_log[i], exp_data[i]); end
        end
        checks++; if (done_cyc_log.size() !== 1) begin errors++; $display("FAIL vadd_done_pulses: got %0d expected 1", done_cyc_log.size()); end
        if (done_cyc_log.size() > 0 && wb_cyc_log.size() > 0) begin
            checks++; if (done_cyc_log[0] !== wb_cyc_log[wb_cyc_log.size()-1] + 1) begin errors++; $display("FAIL vadd_done_cycle: got %0d expected %0d", done_cyc_log[0], wb_cyc_log[wb_cyc_log.size()-1] + 1); end
        end
        checks++; if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL vadd_back_to_idle: got ready=%b busy=%b expected ready=1 busy=0", issue_ready_o, busy_o); end
    endtask

    task automatic test_vmul_backpressure();
        int icyc;
        s1_k = 1; s1_b = 1; s2_k = 0; s2_b = 3;
        lat_max = 1;
        clear_logs();
        wb_hold_until = cyc + 12;
        wb_mode = 1;
        do_issue(OP_MUL, 1'b0, 2'd2, 8, icyc);
        checks++; if (icyc < 0) begin errors++; $display("FAIL vmul_issue: got timeout expected handshake"); end
        for (int k = 0; k < 200 && done_cyc_log.size() == 0; k++) begin
            @(negedge clk_i);
            #2;
        end
        repeat (2) @(negedge clk_i);
        #2;
        wb_mode = 0;
        checks++; if (reqs_before_first_wb !== 4) begin errors++; $display("FAIL vmul_credit_limit: got %0d expected 4", reqs_before_first_wb); end
        checks++; if (wb_idx_log.size() !== 8) begin errors++; $display("FAIL vmul_wb_count: got %0d expected 8", wb_idx_log.size()); end
        for (int i = 0; i < 8 && i < wb_idx_log.size(); i++) begin
            checks++; if (wb_idx_log[i] !== i || wb_data_log[i] !== 32'(3 * (i + 1))) begin errors++; $display("FAIL vmul_entry[%0d]: got idx %0d data %0d expected idx %0d data %0d", i, wb_idx_log[i], wb_data_log[i], i, 3 * (i + 1)); end
        end
        checks++; if (stab_errs !== 0) begin errors++; $display("FAIL vmul_wb_stable: got %0d violations expected 0", stab_errs); end
        checks++; if (max_inflight > 4) begin errors++; $display("FAIL vmul_inflight: got %0d expected <= 4", max_inflight); end
        checks++; if (done_cyc_log.size() !== 1) begin errors++; $display("FAIL vmul_done_pulses: got %0d expected 1", done_cyc_log.size()); end
    endtask

    task automatic test_vl_zero();
        int icyc;
        lat_max = 1;
        wb_mode = 0;
        clear_logs();
        do_issue(OP_ADD, 1'b0, 2'd0, 0, icyc);
        repeat (5) @(negedge clk_i);
        #2;
        checks++; if (icyc < 0) begin errors++; $display("FAIL vl0_issue: got timeout expected handshake"); end
        checks++; if (req_total !== 0) begin errors++; $display("FAIL vl0_requests: got %0d expected 0", req_total); end
        checks++; if (wb_total !== 0) begin errors++; $display("FAIL vl0_writebacks: got %0d expected 0", wb_total); end
        checks++; if (done_cyc_log.size() !== 1) begin errors++; $display("FAIL vl0_done_pulses: got %0d expected 1", done_cyc_log.size()); end
        if (done_cyc_log.size() > 0) begin
            checks++; if (done_cyc_log[0] !== icyc + 1) begin errors++; $display("FAIL vl0_done_cycle: got %0d expected %0d", done_cyc_log[0], icyc + 1); end
        end
    endtask

    task automatic test_vsub_random();
        int icyc;
        logic [31:0] exp_v;
        bit ascending;
        s1_k = 7; s1_b = 3; s2_k = 0; s2_b = 50;
        lat_max = 3;
        wb_mode = 2;
        clear_logs();
        do_issue(OP_SUB, 1'b1, 2'd2, 16, icyc);
        checks++; if (icyc < 0) begin errors++; $display("FAIL vsub_issue: got timeout expected handshake"); end
        for (int k = 0; k < 600 && done_cyc_log.size() == 0; k++) begin
            @(negedge clk_i);
            #2;
        end
        repeat (2) @(negedge clk_i);
        #2;
        wb_mode = 0;
        checks++; if (wb_idx_log.size() !== 16) begin errors++; $display("FAIL vsub_wb_count: got %0d expected 16", wb_idx_log.size()); end
        ascending = 1'b1;
        for (int i = 0; i < 16 && i < wb_idx_log.size(); i++) begin
            exp_v = 32'(50 - (7 * i + 3));
            if (wb_idx_log[i] !== i) ascending = 1'b0;
            checks++; if (wb_data_log[i] !== exp_v) begin errors++; $display("FAIL vsub_data[%0d]: got %0d expected %0d", i, wb_data_log[i], exp_v); end
        end
        checks++; if (!ascending) begin errors++; $display("FAIL vsub_idx_order: got non-ascending expected 0..15"); end
        checks++; if (max_inflight > 4) begin errors++; $display("FAIL vsub_inflight: got %0d expected <= 4", max_inflight); end
        checks++; if (stab_errs !== 0) begin errors++; $display("FAIL vsub_wb_stable: got %0d violations expected 0", stab_errs); end
        checks++; if (done_cyc_log.size() !== 1) begin errors++; $display("FAIL vsub_done_pulses: got %0d expected 1", done_cyc_log.size()); end
    endtask

    task automatic test_reset_mid();
        int icyc;
        s1_k = 1; s1_b = 0; s2_k = 2; s2_b = 0;
        lat_max = 1;
        wb_mode = 0;
        clear_logs();
        do_issue(OP_ADD, 1'b1, 2'd1, 8, icyc);
        for (int k = 0; k < 100 && wb_total < 3; k++) begin
            @(negedge clk_i);
            #2;
        end
        checks++; if (wb_total !== 3) begin errors++; $display("FAIL rstmid_progress: got %0d expected 3", wb_total); end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_issue_ready: got %b expected 1", issue_ready_o); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done: got busy=%b done=%b expected 0 0", busy_o, done_o); end
        checks++; if (opnd_req_valid_o !== 1'b0 || opnd_req_idx_o !== 8'd0) begin errors++; $display("FAIL rstmid_req: got valid=%b idx=%0d expected 0 0", opnd_req_valid_o, opnd_req_idx_o); end
        checks++; if (wb_valid_o !== 1'b0 || wb_idx_o !== 8'd0 || wb_data_o !== 32'd0) begin errors++; $display("FAIL rstmid_wb: got valid=%b idx=%0d data=%0d expected 0 0 0", wb_valid_o, wb_idx_o, wb_data_o); end
        checks++; if (lane_op_o !== 4'd0 || lane_signed_o !== 1'b0 || lane_sew_o !== 2'd0 || lane_s1_o !== 32'd0 || lane_s2_o !== 32'd0) begin errors++; $display("FAIL rstmid_lane: got op=%0d sgn=%b sew=%0d s1=%0d s2=%0d expected all 0", lane_op_o, lane_signed_o, lane_sew_o, lane_s1_o, lane_s2_o); end
        @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        s1_k = 1; s1_b = 20; s2_k = 1; s2_b = 1;
        clear_logs();
        do_issue(OP_ADD, 1'b0, 2'd2, 2, icyc);
        for (int k = 0; k < 100 && done_cyc_log.size() == 0; k++) begin
            @(negedge clk_i);
            #2;
        end
        repeat (2) @(negedge clk_i);
        #2;
        checks++; if (wb_idx_log.size() !== 2) begin errors++; $display("FAIL rstmid_after_count: got %0d expected 2", wb_idx_log.size()); end
        if (wb_idx_log.size() == 2) begin
            checks++; if (wb_idx_log[0] !== 0 || wb_data_log[0] !== 32'd21) begin errors++; $display("FAIL rstmid_after_e0: got idx %0d data %0d expected idx 0 data 21", wb_idx_log[0], wb_data_log[0]); end
            checks++; if (wb_idx_log[1] !== 1 || wb_data_log[1] !== 32'd23) begin errors++; $display("FAIL rstmid_after_e1: got idx %0d data %0d expected idx 1 data 23", wb_idx_log[1], wb_data_log[1]); end
        end
        checks++; if (done_cyc_log.size() !== 1) begin errors++; $display("FAIL rstmid_after_done: got %0d expected 1", done_cyc_log.size()); end
    endtask

    task automatic test_wb_latency();
        int icyc;
        int exp_lat;
`ifdef SPATZ_LANE_SEQ_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 1;
`endif
        s1_k = 0; s1_b = 5; s2_k = 0; s2_b = 6;
        lat_max = 1;
        wb_mode = 0;
        clear_logs();
        do_issue(OP_ADD, 1'b0, 2'd2, 1, icyc);
        for (int k = 0; k < 50 && done_cyc_log.size() == 0; k++) begin
            @(negedge clk_i);
            #2;
        end
        repeat (2) @(negedge clk_i);
        #2;
        checks++; if (rsp_cyc_log.size() !== 1 || first_wbvalid_cyc < 0) begin errors++; $display("FAIL lat_observed: got rsp=%0d wbvalid_cyc=%0d expected 1 response and a write-back", rsp_cyc_log.size(), first_wbvalid_cyc); end
        if (rsp_cyc_log.size() == 1 && first_wbvalid_cyc >= 0) begin
            checks++; if (first_wbvalid_cyc - rsp_cyc_log[0] !== exp_lat) begin errors++; $display("FAIL lat_rsp_to_wb: got %0d expected %0d", first_wbvalid_cyc - rsp_cyc_log[0], exp_lat); end
        end
        checks++; if (wb_data_log.size() !== 1 || wb_data_log[0] !== 32'd11) begin errors++; $display("FAIL lat_data: got %0d entries expected one entry of 11", wb_data_log.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vadd();
        test_vmul_backpressure();
        test_vl_zero();
        test_vsub_random();
        test_reset_mid();
        test_wb_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spatz_lane_sequencer.md
# spatz_lane_sequencer

Element sequencer that sits in front of one SIMD lane (the combinational lane ALU) inside the VFU. It accepts one vector instruction at a time and fetches operand triples element by element from the register-file read port. It drives the lane's operation and operand inputs, captures the lane result and returns it with its element index on a write-back handshake. Flow control is credit-based, so operand responses never need backpressure.

## Interface
- `Width`, 32: lane/element width in bits.
- `MaxVl`, 256: maximum vector length; `VlWidth = $clog2(MaxVl+1)`.
- `ResultDepth`, 4: result FIFO depth, which is also the credit count (≥2).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `issue_valid_i` / `issue_ready_o`  in/out  1  instruction handshake.
- `issue_op_i`  in  op_e  operation.
- `issue_vl_i`  in  VlWidth  element count (0..MaxVl).
- `issue_signed_i`  in  1  signedness.
- `issue_sew_i`  in  rvv_pkg::vew_e  element width.
- `opnd_req_valid_o` / `opnd_req_ready_i`  out/in  1  operand read request handshake.
- `opnd_req_idx_o`  out  VlWidth-1  element index requested.
- `opnd_rsp_valid_i`  in  1  operand response, in request order, no ready.
- `opnd_rsp_s1_i`, `opnd_rsp_s2_i`, `opnd_rsp_d_i`  in  Width  operands.
- `opnd_rsp_carry_i`  in  1  carry/borrow/mask bit.
- `lane_op_o`, `lane_signed_o`, `lane_sew_o`  out  –  latched instruction fields to the lane.
- `lane_s1_o`, `lane_s2_o`, `lane_d_o`  out  Width  lane operands.
- `lane_carry_o`  out  1  lane carry.
- `lane_result_i`  in  Width  combinational lane result.
- `wb_valid_o` / `wb_ready_i`  out/in  1  write-back handshake.
- `wb_idx_o`  out  VlWidth-1  element index.
- `wb_data_o`  out  Width  result.
- `busy_o`  out  1  high in RUN or DONE.
- `done_o`  out  1  one-cycle pulse on instruction completion.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `issue_ready_o`=1.
  - On handshake, latch op, vl, signed and sew, and clear `req_cnt`, `rsp_cnt`, `wb_cnt`.
  - vl≠0 → RUN. vl=0 → DONE directly.
- RUN:
  - `opnd_req_valid_o` = (`req_cnt`<vl) && (`outstanding`+`fifo_count` < ResultDepth).
  - `opnd_req_idx_o`=`req_cnt`; `req_cnt`++ on request handshake.
  - `outstanding` increments on request handshake and decrements on `opnd_rsp_valid_i`. Both in the same cycle → unchanged.
  - Credit check uses registered counts only. A write-back in cycle t frees its credit from t+1.
- Lane drive:
  - Lane operands/carry = response fields when `opnd_rsp_valid_i`, else 0.
  - `lane_op_o`/`lane_signed_o`/`lane_sew_o` hold the latched fields for the whole instruction; reset/IDLE value is op 0, signed 0, sew 0.
- On `opnd_rsp_valid_i`: push {`rsp_cnt`, `lane_result_i`} into the result FIFO and increment `rsp_cnt`.
- Write-back:
  - FIFO head → `wb_*`; pop on handshake; `wb_cnt`++.
  - `wb_valid_o` must stay asserted with stable data until accepted.
- RUN → DONE when `wb_cnt` reaches vl (including the final handshake cycle).
- DONE: `done_o`=1 for exactly one cycle, then IDLE. `issue_ready_o`=0 in DONE.
- FIFO overflow cannot occur by construction. The following are protocol errors, flagged by an assertion:
  - `opnd_rsp_valid_i` with `outstanding`=0.
  - `opnd_rsp_valid_i` outside RUN.
- Simultaneous FIFO push and pop: allowed, count unchanged; a push into a full FIFO with a pop in the same cycle is legal.
- Reset (asynchronous, any state, mid-instruction included):
  - FSM → IDLE; all counters and FIFO cleared; in-flight responses are discarded.
  - Output values: `issue_ready_o`=1; all other outputs 0.

## Timing
- Issue to first request: request valid in the cycle after the issue handshake.
- Request to response: any latency ≥1 cycle; responses in order.
- Response to write-back: response in cycle t → `wb_valid_o` in t+1 (registered FIFO).
- Sustained throughput: 1 element/cycle when response latency + 2 ≤ ResultDepth and `wb_ready_i`=1.
- Completion: last write-back handshake in t → `done_o` in t+1 → `issue_ready_o` in t+2.

## Configuration
- `SPATZ_LANE_SEQ_BYPASS_EN`, when defined: if the FIFO is empty and `opnd_rsp_valid_i`=1, the lane result and index drive `wb_*` in the same cycle (zero latency).
  - If `wb_ready_i`=1, nothing is pushed.
  - Otherwise the entry is pushed and presented from the FIFO in the next cycle. `wb_data_o` may then change only because the source moved into the FIFO; the value stays identical.
- Without the macro, write-back is always registered (1-cycle latency); no combinational path from `opnd_rsp_*`/`lane_result_i` to `wb_*`.

## Test plan
- Bench connects the team's SIMD lane on the `lane_*` ports.
- VADD, vl=4, s1={1,2,3,4}, s2=10, 1-cycle response, `wb_ready_i`=1 → wb idx 0..3 with data {11,12,13,14}; `done_o` one cycle after the last write-back.
- VMUL, vl=8, `wb_ready_i` low for 10 cycles at start → at most ResultDepth=4 requests issued before the first write-back; then all 8 products written in order, no drops.
- vl=0 issue → no operand request, no write-back; `done_o` pulses in the cycle after the issue handshake.
- VSUB, vl=16, random response latency 1–3 and random `wb_ready_i` → results equal s2−s1 with carry 0, indices 0..15 strictly ascending, `outstanding`+`fifo_count` never exceeds 4.
- Assert `rst_i` mid-instruction (after 3 of vl=8 write-backs) → all outputs 0 except `issue_ready_o`=1; a following VADD vl=2 completes correctly from idx 0.
- With `SPATZ_LANE_SEQ_BYPASS_EN`: VADD vl=1, response in cycle t with `wb_ready_i`=1 → `wb_valid_o` in cycle t; without the macro → cycle t+1.
